// File: rtl/simon_pkg.sv
// Shared SIMON32/64 definitions: word width, round constants and the controller state type.
package simon_pkg;

   localparam int WORD_W = 16;
   localparam logic [WORD_W-1:0] C = 16'h0003;

   typedef enum logic [1:0] {IDLE, ROUND, DONE} simonState_t;

   function automatic logic [61:0] reverseZ(input logic [61:0] v);
      logic [61:0] res;
      for (int i = 0; i < 62; i++) res[i] = v[61-i];
      return res;
   endfunction

   // Written as published (element 0 leftmost), stored with element i at bit i.
   localparam logic [61:0] Z0 =
      reverseZ(62'b11111010001001010110000111001101111101000100101011000011100110);

endpackage

// File: rtl/leftCircShift.sv
// Fixed-amount left circular rotate; pure wiring.
module leftCircShift #(
   parameter int WIDTH = 16,
   parameter int SHIFT = 1
) (
   input  logic [WIDTH-1:0] dataIn,
   output logic [WIDTH-1:0] dataOut
);

   assign dataOut = {dataIn[WIDTH-1-SHIFT:0], dataIn[WIDTH-1:WIDTH-SHIFT]};

endmodule

// File: rtl/simon_round_fn.sv
// One SIMON32/64 Feistel round plus the matching key-schedule step, purely combinational.
module simon_round_fn
   import simon_pkg::*;
(
   input  logic [WORD_W-1:0] x,
   input  logic [WORD_W-1:0] y,
   input  logic [WORD_W-1:0] k0,
   input  logic [WORD_W-1:0] k1,
   input  logic [WORD_W-1:0] k3,
   input  logic              zBit,
   output logic [WORD_W-1:0] xNext,
   output logic [WORD_W-1:0] kNew
);

   logic [WORD_W-1:0] s1, s2, s8, fx, tmpA, tmpB;

   leftCircShift #(.WIDTH(WORD_W), .SHIFT(1)) uRot1 (.dataIn(x), .dataOut(s1));
   leftCircShift #(.WIDTH(WORD_W), .SHIFT(2)) uRot2 (.dataIn(x), .dataOut(s2));
   leftCircShift #(.WIDTH(WORD_W), .SHIFT(8)) uRot8 (.dataIn(x), .dataOut(s8));

   assign fx    = (s1 & s8) ^ s2;
   assign xNext = y ^ fx ^ k0;

   // k2 does not feed the m=4 schedule; it only shifts through the register file.
   assign tmpA = {k3[2:0], k3[WORD_W-1:3]} ^ k1;
   assign tmpB = tmpA ^ {tmpA[0], tmpA[WORD_W-1:1]};
   assign kNew = ~k0 ^ tmpB ^ {{(WORD_W-1){1'b0}}, zBit} ^ C;

endmodule

// File: rtl/simon_encrypt_ctrl.sv
// Iterative SIMON32/64 encryption: one round per clock, round keys generated on the fly.
module simon_encrypt_ctrl #(
   parameter int WORD_W = 16,
   parameter int ROUNDS = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WORD_W-1:0]       pt_x,
   input  logic [WORD_W-1:0]       pt_y,
   input  logic [63:0]             key,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WORD_W-1:0]       ct_x,
   output logic [WORD_W-1:0]       ct_y,
   output logic                    busy,
   output logic [5:0]              round_idx,
   output simon_pkg::simonState_t  stateDbg
);
   import simon_pkg::*;

   // Handshakes: a transfer occurs on a rising edge where valid and ready are both high;
   // valid/data are held by the producer until then, and ready never depends on valid.

   localparam logic [5:0] LAST = 6'(ROUNDS - 1);

   simonState_t       state;
   logic [WORD_W-1:0] xReg, yReg, xNext, kNew;
   logic [WORD_W-1:0] kReg [4];
   logic [5:0]        r;

   simon_round_fn uRound (
      .x    (xReg),
      .y    (yReg),
      .k0   (kReg[0]),
      .k1   (kReg[1]),
      .k3   (kReg[3]),
      .zBit (Z0[r]),
      .xNext(xNext),
      .kNew (kNew)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         xReg      <= '0;
         yReg      <= '0;
         for (int i = 0; i < 4; i++) kReg[i] <= '0;
         r         <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  xReg <= pt_x;
                  yReg <= pt_y;
                  for (int i = 0; i < 4; i++) kReg[i] <= key[i*WORD_W +: WORD_W];
                  r        <= '0;
                  state    <= ROUND;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            ROUND: begin
               xReg    <= xNext;
               yReg    <= xReg;
               kReg[0] <= kReg[1];
               kReg[1] <= kReg[2];
               kReg[2] <= kReg[3];
               kReg[3] <= kNew;
               // r returns to 0 so round_idx reads 0 while the result is held.
               if (r == LAST) begin
                  r         <= '0;
                  state     <= DONE;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
               end else begin
                  r <= r + 6'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               r         <= '0;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   assign ct_x      = xReg;
   assign ct_y      = yReg;
   assign round_idx = r;
   assign stateDbg  = state;

endmodule

// File: tb/tb_simon_encrypt_ctrl.sv
// Directed-vector bench for simon_encrypt_ctrl with a ciphertext scoreboard.
module tb_simon_encrypt_ctrl;

   localparam int ROUNDS = 32;
   localparam logic [63:0] STD_KEY = 64'h1918_1110_0908_0100;
   localparam logic [15:0] STD_PX  = 16'h6565;
   localparam logic [15:0] STD_PY  = 16'h6877;
   localparam logic [31:0] STD_CT  = 32'hc69b_e9bb;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [15:0] pt_x = '0;
   logic [15:0] pt_y = '0;
   logic [63:0] key = '0;
   logic        in_ready, out_valid, busy;
   logic [15:0] ct_x, ct_y;
   logic [5:0]  round_idx;
   simon_pkg::simonState_t stateDbg;

   int testsRun = 0;
   int testsFailed = 0;
   logic [31:0] exp_q[$];

   simon_encrypt_ctrl #(.WORD_W(16), .ROUNDS(ROUNDS)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .pt_x     (pt_x),
      .pt_y     (pt_y),
      .key      (key),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .ct_x     (ct_x),
      .ct_y     (ct_y),
      .busy     (busy),
      .round_idx(round_idx),
      .stateDbg (stateDbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no end, expected summary");
      $fatal(1, "watchdog expired");
   end

   // reference model
   function automatic logic [15:0] rol16(input logic [15:0] v, input int n);
      return (v << n) | (v >> (16 - n));
   endfunction

   function automatic logic [15:0] ror16(input logic [15:0] v, input int n);
      return (v >> n) | (v << (16 - n));
   endfunction

   function automatic logic [31:0] simonModel(input logic [63:0] keyIn, input logic [31:0] pt);
      logic [15:0] rk [0:ROUNDS+3];
      logic [15:0] xm, ym, tmp, fx;
      logic [61:0] zs;
      zs = 62'b11111010001001010110000111001101111101000100101011000011100110;
      for (int i = 0; i < 4; i++) rk[i] = keyIn[16*i +: 16];
      for (int i = 0; i < ROUNDS - 4; i++) begin
         tmp = ror16(rk[i+3], 3) ^ rk[i+1];
         tmp = tmp ^ ror16(tmp, 1);
         rk[i+4] = ~rk[i] ^ tmp ^ {15'b0, zs[61-i]} ^ 16'h0003;
      end
      xm = pt[31:16];
      ym = pt[15:0];
      for (int i = 0; i < ROUNDS; i++) begin
         fx = (rol16(xm, 1) & rol16(xm, 8)) ^ rol16(xm, 2);
         {xm, ym} = {ym ^ fx ^ rk[i], xm};
      end
      return {xm, ym};
   endfunction

   // checking
   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] expv);
      testsRun++;
      if (got !== expv) begin
         testsFailed++;
         $display("FAIL %s: got %h expected %h", tag, got, expv);
      end
   endtask

   task automatic checkCt(output logic [31:0] expOut);
      expOut = '0;
      checkVal("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
         expOut = exp_q.pop_front();
         checkVal("ciphertext", {ct_x, ct_y}, expOut);
      end
   endtask

   task automatic checkResetState(input string tag);
      checkVal({tag, "_in_ready"},  32'(in_ready),  32'd1);
      checkVal({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      checkVal({tag, "_busy"},      32'(busy),      32'd0);
      checkVal({tag, "_round_idx"}, 32'(round_idx), 32'd0);
      checkVal({tag, "_ct"},        {ct_x, ct_y},   32'd0);
      checkVal({tag, "_state"},     32'(stateDbg),  32'(simon_pkg::IDLE));
   endtask

   // driver: starts and ends on a falling edge
   task automatic runBlock(input logic [63:0] k, input logic [15:0] px, input logic [15:0] py,
                           input int pulseRound, input int abortRound);
      int  lat, busyCnt, readyCnt;
      bit  aborted;
      checkVal("accept_in_ready", 32'(in_ready), 32'd1);
      key = k; pt_x = px; pt_y = py; in_valid = 1'b1;
      @(negedge clk);
      lat = 0; busyCnt = 0; readyCnt = 0; aborted = 1'b0;
      while (!out_valid && lat < 200) begin
         checkVal("round_idx", 32'(round_idx), 32'(lat));
         if (busy) busyCnt++;
         if (in_ready) readyCnt++;
         if (lat == abortRound) begin
            rst_n = 1'b0;
            #1;
            checkResetState("abort");
            @(negedge clk);
            rst_n = 1'b1;
            aborted = 1'b1;
            break;
         end
         in_valid = (lat == pulseRound);
         key  = {$urandom, $urandom};
         pt_x = 16'($urandom);
         pt_y = 16'($urandom);
         @(negedge clk);
         lat++;
      end
      in_valid = 1'b0;
      if (!aborted) begin
         checkVal("latency",          32'(lat),       32'(ROUNDS));
         checkVal("busy_cycles",      32'(busyCnt),   32'(ROUNDS));
         checkVal("in_ready_busy",    32'(readyCnt),  32'd0);
         checkVal("round_idx_done",   32'(round_idx), 32'd0);
         checkVal("busy_done",        32'(busy),      32'd0);
         checkVal("state_done",       32'(stateDbg),  32'(simon_pkg::DONE));
      end
   endtask

   initial begin
      logic [31:0] held;
      int gap, lat2, stable;
      bit found;

      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checkResetState("reset");
      rst_n = 1'b1;
      @(negedge clk);
      checkVal("idle_after_release", 32'(in_ready), 32'd1);

      // standard vector, then 10 cycles of backpressure with noise on the input side
      exp_q.push_back(STD_CT);
      runBlock(STD_KEY, STD_PX, STD_PY, -1, -1);
      checkCt(held);
      stable = 0;
      for (int i = 0; i < 10; i++) begin
         if (out_valid && !in_ready && ({ct_x, ct_y} == held)) stable++;
         in_valid = 1'b1;
         key = {$urandom, $urandom};
         pt_x = 16'($urandom);
         pt_y = 16'($urandom);
         @(negedge clk);
      end
      checkVal("backpressure_stable", 32'(stable), 32'd10);
      checkVal("backpressure_held_ct", {ct_x, ct_y}, held);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      checkVal("release_out_valid", 32'(out_valid), 32'd0);
      checkVal("release_in_ready",  32'(in_ready),  32'd1);
      out_ready = 1'b0;

      // in_valid pulse at round 5 is ignored; out_ready high from the start
      out_ready = 1'b1;
      exp_q.push_back(STD_CT);
      runBlock(STD_KEY, STD_PX, STD_PY, 5, -1);
      checkCt(held);
      @(negedge clk);
      checkVal("early_ready_out_valid", 32'(out_valid), 32'd0);
      checkVal("early_ready_in_ready",  32'(in_ready),  32'd1);
      out_ready = 1'b0;

      // reset at round 17 aborts, then a clean run
      runBlock(STD_KEY, STD_PX, STD_PY, -1, 17);
      checkVal("post_abort_in_ready", 32'(in_ready), 32'd1);
      exp_q.push_back(STD_CT);
      runBlock(STD_KEY, STD_PX, STD_PY, -1, -1);
      checkCt(held);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // back-to-back: in_valid held high, standard block then all-zero block
      out_ready = 1'b1;
      key = STD_KEY; pt_x = STD_PX; pt_y = STD_PY; in_valid = 1'b1;
      exp_q.push_back(STD_CT);
      checkVal("b2b_first_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      key = '0; pt_x = '0; pt_y = '0;
      exp_q.push_back(simonModel(64'h0, 32'h0));
      gap = 0;
      found = 1'b0;
      for (int t = 0; t < 200 && !found; t++) begin
         if (out_valid) checkCt(held);
         if (in_ready) begin
            gap = t + 1;
            found = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      checkVal("b2b_accept_gap", 32'(gap), 32'(ROUNDS + 2));
      @(negedge clk);
      in_valid = 1'b0;
      lat2 = 0;
      while (!out_valid && lat2 < 200) begin
         @(negedge clk);
         lat2++;
      end
      checkVal("b2b_second_latency", 32'(lat2), 32'(ROUNDS));
      checkCt(held);
      @(negedge clk);
      checkVal("b2b_idle_after", 32'(in_ready), 32'd1);
      out_ready = 1'b0;
      checkVal("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/simon_encrypt_ctrl.md
# simon_encrypt_ctrl

Iterative SIMON32/64 encryption engine. It accepts a 32-bit plaintext block and a 64-bit key through a valid/ready handshake, and sequences one Feistel round per clock for 32 rounds. It generates round keys on the fly and presents the 32-bit ciphertext through a second valid/ready handshake. It sits between the host-side block interface and the combinational rotate/round datapath, and owns every round counter, key register and state register in the cipher core.

## Interface

Parameters:
- WORD_W, 16, word width n; only 16 is supported.
- ROUNDS, 32, number of rounds T; legal range 1..62.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  plaintext/key present.
- in_ready  out  1  block can accept; equals (state == IDLE).
- pt_x  in  16  plaintext upper word x.
- pt_y  in  16  plaintext lower word y.
- key  in  64  key words; k0 = key[15:0], k1 = key[31:16], k2 = key[47:32], k3 = key[63:48].
- out_valid  out  1  ciphertext valid; equals (state == DONE).
- out_ready  in  1  consumer takes ciphertext.
- ct_x  out  16  ciphertext upper word; reads the x register.
- ct_y  out  16  ciphertext lower word; reads the y register.
- busy  out  1  high in ROUND.
- round_idx  out  6  current round number, 0..ROUNDS-1; 0 outside ROUND.

## Operation

- States:
  - IDLE: in_ready = 1. When in_valid is high, load x = pt_x, y = pt_y, k[0..3] from key, set r = 0, and go to ROUND.
  - ROUND: perform one round per cycle. When r == ROUNDS-1, update and go to DONE; otherwise r = r + 1.
  - DONE: out_valid = 1 and the registers are held. When out_ready is high, go to IDLE.
- Round update, performed every ROUND cycle:
  - f(x) = (S1 x & S8 x) ^ S2 x, where Sj is a left circular rotate by j.
  - x' = y ^ f(x) ^ k[0].
  - y' = x.
- Key update, performed in the same cycle:
  - tmp = S^-3 k[3] ^ k[1].
  - tmp = tmp ^ S^-1 tmp.
  - knew = ~k[0] ^ tmp ^ z0[r] ^ 16'h0003, where z0[r] is a single bit occupying bit 0 of the XOR term.
  - Shift: k[0] = k[1], k[1] = k[2], k[2] = k[3], k[3] = knew.
- z0 is the SIMON sequence 11111010001001010110000111001101111101000100101011000011100110. Element 0 is the leftmost digit. The package constant stores element i at bit i.
- Width rules:
  - All XOR/AND operations are 16-bit and modulo-free.
  - Rotates wrap; nothing is dropped.
  - r never exceeds 61, so no modulo on z0 is needed.
- Input capture:
  - in_valid is ignored outside IDLE.
  - Input words are sampled only on the accept edge and may change afterwards without effect.
- Output hold: in DONE, ct_x and ct_y stay stable until the handshake completes, regardless of input activity.

## Timing

- Reset (asynchronous, any state) forces:
  - state = IDLE, with in_ready = 1 while rst_n is low and after release.
  - out_valid = 0, busy = 0.
  - x, y and k[0..3] = 0; r = 0; round_idx = 0.
- Reset mid-round aborts the operation with no output.
- Accept on edge E (in_valid & in_ready):
  - Rounds execute on edges E+1 .. E+ROUNDS.
  - out_valid is high after edge E+ROUNDS. Latency is ROUNDS cycles (32 by default).
- out_ready:
  - If out_ready is high in the first DONE cycle, out_valid drops and in_ready rises after the next edge.
  - out_ready held high early has no effect before DONE.
  - Back-to-back block rate is ROUNDS + 2 cycles per block; accept is never overlapped with DONE.
- round_idx equals r during ROUND; ROUNDS-1 is visible in the last ROUND cycle.

## Structure

Shared package simon_pkg holds:
- WORD_W;
- the 62-bit Z0 constant;
- the 16'h0003 constant C;
- the state enum {IDLE, ROUND, DONE}.

One combinational sub-module, simon_round_fn, computes x' and knew from x, y and k[0..3] plus the z bit. It reuses the existing leftCircShift rotate block for S1, S2 and S8, and has local right-rotate wiring for S^-1 and S^-3. The FSM, counter and registers live in simon_encrypt_ctrl.

## Test plan

- Standard vector: key 64'h1918_1110_0908_0100, pt_x 16'h6565, pt_y 16'h6877 -> ct_x 16'hc69b, ct_y 16'he9bb, with out_valid rising exactly 32 edges after accept.
- Backpressure: out_ready held low for 10 cycles in DONE -> out_valid and the ct words remain stable and in_ready stays 0; release -> IDLE one edge later.
- Ignore during busy: pulse in_valid with a different pt/key at round 5 -> result is still c69b/e9bb and in_ready stays 0 throughout ROUND.
- Mid-operation reset: assert rst_n = 0 at round 17 -> outputs and state return to reset values immediately; the next standard vector run yields c69b/e9bb.
- Back-to-back: in_valid held high with two blocks (standard vector, then all-zero pt/key) and out_ready high -> second accept occurs ROUNDS+2 cycles after the first, and both ciphertexts match the software model.
- round_idx sweep: round_idx counts 0..31 across ROUND and is 0 in IDLE and DONE; busy is high for exactly 32 cycles.
